// File: rtl/sys_arr_pkg.sv
// Shared types and constants for the 2x2 systolic array host-side feeder.
package sys_arr_pkg;

  localparam int DEFAULT_DW = 32;
  localparam int DEFAULT_RW = 64;
  localparam int N          = 2;
  localparam int SKEW_STEPS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } feeder_state_t;

  // Element positions within the packed {x11,x10,x01,x00} operand words
  localparam int IDX_00 = 0;
  localparam int IDX_01 = 1;
  localparam int IDX_10 = 2;
  localparam int IDX_11 = 3;

endpackage

// File: rtl/systolic_skew_gen.sv
// Latches one job's A/B operands and emits the three registered skewed beats
// (row/col streams plus load) that fill the 2x2 array.
module systolic_skew_gen
  import sys_arr_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4*DW-1:0] a,
  input  logic [4*DW-1:0] b,
  output logic            load,
  output logic [DW-1:0]   row0,
  output logic [DW-1:0]   row1,
  output logic [DW-1:0]   col0,
  output logic [DW-1:0]   col1,
  output logic            last
);

  localparam logic [1:0] LAST_STEP = 2'(SKEW_STEPS - 1);

  function automatic logic [DW-1:0] elem(input logic [4*DW-1:0] m, input int idx);
    return m[idx*DW +: DW];
  endfunction

  logic [4*DW-1:0] a_r, b_r, a_sel_s, b_sel_s;
  logic [1:0]      step_r, step_nxt_s;
  logic            active_r, active_nxt_s;
  logic [DW-1:0]   row0_r, row1_r, col0_r, col1_r;
  logic [DW-1:0]   row0_nxt_s, row1_nxt_s, col0_nxt_s, col1_nxt_s;
  logic            load_r;

  // Step sequencing and skew-table lookup; step 0 comes straight from the inputs
  always_comb begin
    a_sel_s      = a_r;
    b_sel_s      = b_r;
    step_nxt_s   = step_r;
    active_nxt_s = 1'b0;
    row0_nxt_s   = '0;
    row1_nxt_s   = '0;
    col0_nxt_s   = '0;
    col1_nxt_s   = '0;
    if (start) begin
      a_sel_s      = a;
      b_sel_s      = b;
      step_nxt_s   = 2'd0;
      active_nxt_s = 1'b1;
    end else if (active_r && (step_r != LAST_STEP)) begin
      step_nxt_s   = step_r + 2'd1;
      active_nxt_s = 1'b1;
    end else begin
      step_nxt_s   = 2'd0;
      active_nxt_s = 1'b0;
    end
    if (active_nxt_s) begin
      case (step_nxt_s)
        2'd0: begin
          row0_nxt_s = elem(a_sel_s, IDX_00);
          col0_nxt_s = elem(b_sel_s, IDX_00);
        end
        2'd1: begin
          row0_nxt_s = elem(a_sel_s, IDX_01);
          row1_nxt_s = elem(a_sel_s, IDX_10);
          col0_nxt_s = elem(b_sel_s, IDX_10);
          col1_nxt_s = elem(b_sel_s, IDX_01);
        end
        2'd2: begin
          row1_nxt_s = elem(a_sel_s, IDX_11);
          col1_nxt_s = elem(b_sel_s, IDX_11);
        end
        default: begin
          row0_nxt_s = '0;
          row1_nxt_s = '0;
          col0_nxt_s = '0;
          col1_nxt_s = '0;
        end
      endcase
    end else begin
      row0_nxt_s = '0;
      row1_nxt_s = '0;
      col0_nxt_s = '0;
      col1_nxt_s = '0;
    end
  end

  // Operand latch, step counter and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      step_r   <= 2'd0;
      active_r <= 1'b0;
      load_r   <= 1'b0;
      row0_r   <= '0;
      row1_r   <= '0;
      col0_r   <= '0;
      col1_r   <= '0;
    end else begin
      a_r      <= a_sel_s;
      b_r      <= b_sel_s;
      step_r   <= step_nxt_s;
      active_r <= active_nxt_s;
      load_r   <= active_nxt_s;
      row0_r   <= row0_nxt_s;
      row1_r   <= row1_nxt_s;
      col0_r   <= col0_nxt_s;
      col1_r   <= col1_nxt_s;
    end
  end

  assign load = load_r;
  assign row0 = row0_r;
  assign row1 = row1_r;
  assign col0 = col0_r;
  assign col1 = col1_r;
  assign last = active_r && (step_r == LAST_STEP);

endmodule

// File: rtl/systolic_2x2_feeder.sv
// Host-side driver for the 2x2 systolic multiplier: accepts a job, feeds skewed
// streams, captures the array results and returns them. Option: SYS_FEEDER_TIMEOUT_EN.
module systolic_2x2_feeder
  import sys_arr_pkg::*;
#(
  parameter int DW             = DEFAULT_DW,
  parameter int RW             = DEFAULT_RW,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [4*DW-1:0] s_a,
  input  logic [4*DW-1:0] s_b,
  output logic            load_in,
  output logic [DW-1:0]   row_in_row0,
  output logic [DW-1:0]   row_in_row1,
  output logic [DW-1:0]   col_in_col0,
  output logic [DW-1:0]   col_in_col1,
  input  logic [4*RW-1:0] arr_res,
  input  logic [3:0]      arr_carry,
  input  logic            arr_done,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [4*RW-1:0] m_result,
  output logic [3:0]      m_carry,
  output logic            m_err,
  output logic            busy
);

  feeder_state_t   state_r, state_nxt_s;
  logic            accept_s, capture_s, timeout_s, timeout_hit_s, feed_last_s;
  logic            s_ready_r, m_valid_r, m_err_r, busy_r;
  logic [4*RW-1:0] m_result_r;
  logic [3:0]      m_carry_r;

  systolic_skew_gen #(.DW(DW)) u_skew (
    .clk  (clk),
    .rst  (rst),
    .start(accept_s),
    .a    (s_a),
    .b    (s_b),
    .load (load_in),
    .row0 (row_in_row0),
    .row1 (row_in_row1),
    .col0 (col_in_col0),
    .col1 (col_in_col1),
    .last (feed_last_s)
  );

`ifdef SYS_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_r;

  // Cycles spent in WAIT; held at zero in every other state
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_r != WAIT) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + CW'(1);
    end
  end

  assign timeout_hit_s = (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg_s;
  assign unused_cfg_s  = (TIMEOUT_CYCLES == 0);
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state logic; arr_done only matters in WAIT, and a real done beats a timeout
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (s_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = FEED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FEED: begin
        if (feed_last_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = FEED;
        end
      end
      WAIT: begin
        if (arr_done) begin
          capture_s   = 1'b1;
          state_nxt_s = HOLD;
        end else if (timeout_hit_s) begin
          timeout_s   = 1'b1;
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, registered handshake flags and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      s_ready_r  <= 1'b1;
      busy_r     <= 1'b0;
      m_valid_r  <= 1'b0;
      m_result_r <= '0;
      m_carry_r  <= 4'd0;
      m_err_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      s_ready_r <= (state_nxt_s == IDLE);
      busy_r    <= (state_nxt_s != IDLE);
      m_valid_r <= (state_nxt_s == HOLD);
      if (capture_s) begin
        m_result_r <= arr_res;
        m_carry_r  <= arr_carry;
        m_err_r    <= 1'b0;
      end else if (timeout_s) begin
        m_result_r <= '0;
        m_carry_r  <= 4'd0;
        m_err_r    <= 1'b1;
      end else begin
        m_result_r <= m_result_r;
        m_carry_r  <= m_carry_r;
        m_err_r    <= m_err_r;
      end
    end
  end

  assign s_ready  = s_ready_r;
  assign busy     = busy_r;
  assign m_valid  = m_valid_r;
  assign m_result = m_result_r;
  assign m_carry  = m_carry_r;
  assign m_err    = m_err_r;

endmodule
